// File: rtl/fetch_pkg.sv
// Shared widths, halt encoding and state enumeration for the instruction fetch unit.
package fetch_pkg;
    localparam int ADDR_W = 5;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs; flush clears it.
module fetch_buffer #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] tail;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count stays put; with one entry the new word goes straight to the head.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: walks the PC through instruction memory into a 2-deep buffer,
// stopping on the halt encoding and restarting on redirect.
module instruction_fetch #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  address,
    output logic               rd,
    input  logic [INSTR_W-1:0] instruction_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               halted
);
    import fetch_pkg::*;

    fetch_state_t        state;
    logic [ADDR_W-1:0]   pc;
    logic [1:0]          count;
    logic                pop;
    logic                push_en;
    logic                flush;
    logic [ADDR_W+INSTR_W-1:0] head;

    assign rd       = 1'b1;
    assign address  = pc;
    assign ir_valid = (count != 2'd0);
    assign pop      = ir_valid && ir_ready;
    assign push_en  = (state == RUN) && !redirect && ((count != 2'd2) || pop);
    assign flush    = redirect && (state != IDLE);
    assign {ir_pc, ir} = head;

    fetch_buffer #(
        .W(ADDR_W + INSTR_W)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_en),
        .pop   (pop),
        .flush (flush),
        .din   ({pc, instruction_out}),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (push_en) begin
                        pc <= pc + 1'b1;
                        if (instruction_out == HALT_WORD) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (redirect) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        pc     <= redirect_pc;
                    end
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational memory model.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [4:0]  redirect_pc = '0;
    logic [4:0]  address;
    logic        rd;
    logic [31:0] instruction_out;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] ir;
    logic [4:0]  ir_pc;
    logic        halted;

    logic [31:0] mem [0:31];
    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] BWORD = 32'hB0B0_B0B0;

    always #5 clk = ~clk;
    assign instruction_out = mem[address];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .redirect(redirect),
        .redirect_pc(redirect_pc), .address(address), .rd(rd),
        .instruction_out(instruction_out), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .halted(halted)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the caller at the negedge after the edge that sampled start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got=%b want=0", ir_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b want=0", halted); end
        n_cmp++; if (address !== 5'd0) begin n_fail++; $display("FAIL reset_address got=%0d want=0", address); end
        n_cmp++; if (rd !== 1'b1) begin n_fail++; $display("FAIL reset_rd got=%b want=1", rd); end
        n_cmp++; if (ir !== 32'd0 || ir_pc !== 5'd0) begin n_fail++; $display("FAIL reset_head got=%h/%0d want=0/0", ir, ir_pc); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_redirect();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 5'd7;
        @(negedge clk);
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (address !== 5'd0) begin n_fail++; $display("FAIL idle_redirect_address got=%0d want=0", address); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_valid got=%b want=0", ir_valid); end
    endtask

    task automatic test_basic();
        ir_ready = 1'b1;
        pulse_start();
        n_cmp++; if (ir_valid !== 1'b0 || address !== 5'd0) begin n_fail++; $display("FAIL basic_latency got valid=%b addr=%0d want 0/0", ir_valid, address); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ir_valid !== 1'b1 || ir !== 32'hA000_0000 + i || ir_pc !== 5'(i)) begin
                n_fail++; $display("FAIL basic_seq%0d got=%b/%h/%0d want=1/%h/%0d", i, ir_valid, ir, ir_pc, 32'hA000_0000 + i, i);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        pulse_start();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (address !== 5'((k < 2) ? k : 2) || rd !== 1'b1 || ir_valid !== 1'b1 || ir !== 32'hA000_0000) begin
                n_fail++; $display("FAIL bp_stall%0d got addr=%0d rd=%b v=%b ir=%h want addr=%0d rd=1 v=1 ir=a0000000", k, address, rd, ir_valid, ir, (k < 2) ? k : 2);
            end
        end
        ir_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ir_valid !== 1'b1 || ir !== 32'hA000_0000 + i || ir_pc !== 5'(i)) begin
                n_fail++; $display("FAIL bp_resume%0d got=%b/%h/%0d want=1/%h/%0d", i, ir_valid, ir, ir_pc, 32'hA000_0000 + i, i);
            end
        end
    endtask

    task automatic test_redirect_pop();
        apply_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        n_cmp++; if (address !== 5'd2 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL rdp_full got addr=%0d v=%b want 2/1", address, ir_valid); end
        redirect = 1'b1; redirect_pc = 5'd20; ir_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0 || address !== 5'd20) begin n_fail++; $display("FAIL rdp_flush got v=%b addr=%0d want 0/20", ir_valid, address); end
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir !== mem[20] || ir_pc !== 5'd20) begin n_fail++; $display("FAIL rdp_target got=%b/%h/%0d want=1/%h/20", ir_valid, ir, ir_pc, mem[20]); end
    endtask

    task automatic test_wrap_halt();
        mem[31] = BWORD; mem[0] = HALT;
        redirect = 1'b1; redirect_pc = 5'd31;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL wh_flush got v=%b h=%b want 0/0", ir_valid, halted); end
        @(negedge clk);
        n_cmp++; if (ir !== BWORD || ir_pc !== 5'd31 || halted !== 1'b0) begin n_fail++; $display("FAIL wh_b got=%h/%0d h=%b want=%h/31 h=0", ir, ir_pc, halted, BWORD); end
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir !== HALT || ir_pc !== 5'd0) begin n_fail++; $display("FAIL wh_halt_word got=%b/%h/%0d want=1/%h/0", ir_valid, ir, ir_pc, HALT); end
        n_cmp++; if (halted !== 1'b1 || address !== 5'd1) begin n_fail++; $display("FAIL wh_halted got h=%b addr=%0d want 1/1", halted, address); end
        repeat (3) @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b0 || address !== 5'd1 || halted !== 1'b1) begin n_fail++; $display("FAIL wh_no_push got v=%b addr=%0d h=%b want 0/1/1", ir_valid, address, halted); end
    endtask

    task automatic test_restart();
        redirect = 1'b1; redirect_pc = 5'd5;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rs_halted got=%b want=0", halted); end
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir !== mem[5] || ir_pc !== 5'd5) begin n_fail++; $display("FAIL rs_target got=%b/%h/%0d want=1/%h/5", ir_valid, ir, ir_pc, mem[5]); end
    endtask

    task automatic test_async_reset();
        mem[0] = 32'hA000_0000;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ir_valid !== 1'b0 || address !== 5'd0) begin n_fail++; $display("FAIL ar_immediate got v=%b addr=%0d want 0/0", ir_valid, address); end
        n_cmp++; if (halted !== 1'b0 || rd !== 1'b1) begin n_fail++; $display("FAIL ar_flags got h=%b rd=%b want 0/1", halted, rd); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b0 || address !== 5'd0) begin n_fail++; $display("FAIL ar_wait_start got v=%b addr=%0d want 0/0", ir_valid, address); end
        pulse_start();
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir !== 32'hA000_0000 || ir_pc !== 5'd0) begin n_fail++; $display("FAIL ar_restart got=%b/%h/%0d want=1/a0000000/0", ir_valid, ir, ir_pc); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        test_reset();
        test_idle_redirect();
        test_basic();
        test_backpressure();
        test_redirect_pop();
        test_wrap_halt();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
